// File: rtl/serial_tx_if.sv
// Strobe/byte handshake between the hex-word printer and the UART transmitter.
interface serial_tx_if;
    logic       i_wr;
    logic [7:0] i_data;
    logic       o_busy;

    modport master (output i_wr, output i_data, input  o_busy);
    modport slave  (input  i_wr, input  i_data, output o_busy);
endinterface

// File: rtl/serial_tx.sv
// Byte-wide UART transmitter, 8N1, LSB first; one byte latched per accepted write.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between D7 and STOP.
module serial_tx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    serial_tx_if.slave  bus,
    output logic        o_uart_tx
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [23:0] CNT_LOAD = CLOCKS_PER_BAUD - 24'd1;

    state_t      state, state_nx;
    logic [23:0] cnt, cnt_nx;
    logic [7:0]  sh, sh_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic        tx;
    logic        baud_done;
`ifdef SERIAL_TX_PARITY_EN
    logic        par, par_nx;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= 24'd0;
            sh      <= 8'd0;
            bit_idx <= 3'd0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            sh      <= sh_nx;
            bit_idx <= bit_nx;
`ifdef SERIAL_TX_PARITY_EN
            par     <= par_nx;
`endif
        end
    end

    assign baud_done = (cnt == 24'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        bit_nx   = bit_idx;
        tx       = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        par_nx   = par;
`endif
        // Every non-idle state shares one baud timer, reloaded on each bit boundary.
        if (state != IDLE)
            cnt_nx = baud_done ? CNT_LOAD : cnt - 24'd1;

        case (state)
            IDLE: begin
                if (bus.i_wr) begin
                    state_nx = START;
                    cnt_nx   = CNT_LOAD;
                    sh_nx    = bus.i_data;
                    bit_nx   = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
                    par_nx   = ^bus.i_data;
`endif
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) state_nx = DATA;
            end
            DATA: begin
                tx = sh[0];
                if (baud_done) begin
                    sh_nx  = {1'b0, sh[7:1]};
                    bit_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (baud_done) state_nx = STOP;
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (baud_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_uart_tx  = tx;
    assign bus.o_busy = (state != IDLE);
endmodule
